// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key gesture decoder: FSM state encoding,
// default timing constants and a small state-decode helper.
package key_event_decoder_pkg;

    // One-hot encoding keeps next-state and HELD decode to single-bit tests.
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_PRESS1    = 5'b00010,
        ST_WAIT2     = 5'b00100,
        ST_PRESS2    = 5'b01000,
        ST_LONG_HELD = 5'b10000
    } state_t;

    localparam int DEF_TICK_DIV  = 12000;
    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_DBL_MS    = 300;
    localparam int DEF_REPEAT_MS = 200;
    localparam int DEF_MS_W      = 16;

    // Key is physically down in these states.
    function automatic logic is_held(input state_t s);
        return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG_HELD);
    endfunction

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// The tick is decoded straight from the count so the consumer sees it in the
// same cycle the counter wraps; a synchronous clear restarts the period.
module ms_tick_gen
    import key_event_decoder_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // tick must not depend on clr: clr is itself derived from tick upstream.
    assign tick = (cnt == CNT_LAST);

    // Free-running prescaler, restarted on clear or wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Key gesture decoder: classifies debounced key edges into short press,
// double click, long press and auto-repeat pulses, timed in 1 ms ticks.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | key up, no gesture in progress
//  PRESS1    | first press held, waiting for release or long-press time
//  WAIT2     | first press released, waiting for a second press
//  PRESS2    | second press held, DOUBLE_CLICK fires on its release
//  LONG_HELD | long press reached, REPEAT fires periodically until release
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int DBL_MS    = DEF_DBL_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS,
    parameter int MS_W      = DEF_MS_W
) (
    input  logic CLK,
    input  logic nRST,
    input  logic KEY_FLAG,
    input  logic KEY_STATE,
    output logic SHORT_PRESS,
    output logic DOUBLE_CLICK,
    output logic LONG_PRESS,
    output logic REPEAT,
    output logic HELD
);

    localparam logic [MS_W-1:0] LONG_C   = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] DBL_C    = MS_W'(DBL_MS);
    localparam logic [MS_W-1:0] REPEAT_C = MS_W'(REPEAT_MS);

    state_t          state;
    state_t          state_nxt;
    logic [MS_W-1:0] ms;
    logic [MS_W-1:0] ms_inc;
    logic            press_edge;
    logic            rel_edge;
    logic            tick;
    logic            leave;
    logic            long_hit;
    logic            dbl_hit;
    logic            rpt_hit;

    assign press_edge = KEY_FLAG & ~KEY_STATE;
    assign rel_edge   = KEY_FLAG &  KEY_STATE;

    // Saturating increment so PRESS2, which has no timeout, never wraps.
    assign ms_inc = (ms == {MS_W{1'b1}}) ? ms : ms + MS_W'(1);

    // A timeout fires on the tick that brings ms up to the threshold.
    assign long_hit = tick && (ms_inc == LONG_C);
    assign dbl_hit  = tick && (ms_inc == DBL_C);
    assign rpt_hit  = tick && (ms_inc == REPEAT_C);

    // Next-state decode; key edges are tested ahead of timeouts.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (press_edge) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (rel_edge)      state_nxt = ST_WAIT2;
                else if (long_hit) state_nxt = ST_LONG_HELD;
            end
            ST_WAIT2: begin
                if (press_edge)   state_nxt = ST_PRESS2;
                else if (dbl_hit) state_nxt = ST_IDLE;
            end
            ST_PRESS2: begin
                if (rel_edge) state_nxt = ST_IDLE;
            end
            ST_LONG_HELD: begin
                if (rel_edge) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign leave = (state_nxt != state);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (leave),
        .tick (tick)
    );

    // State, ms counter and registered outputs. Each pulse is tied to the one
    // transition (or repeat event) that produces it, so they are exclusive.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= ST_IDLE;
            ms           <= '0;
            SHORT_PRESS  <= 1'b0;
            DOUBLE_CLICK <= 1'b0;
            LONG_PRESS   <= 1'b0;
            REPEAT       <= 1'b0;
            HELD         <= 1'b0;
        end else begin
            state <= state_nxt;

            if (leave) begin
                ms <= '0;
            end else if ((state == ST_LONG_HELD) && rpt_hit) begin
                ms <= '0;
            end else if (tick) begin
                ms <= ms_inc;
            end

            SHORT_PRESS  <= (state == ST_WAIT2)  && (state_nxt == ST_IDLE);
            DOUBLE_CLICK <= (state == ST_PRESS2) && (state_nxt == ST_IDLE);
            LONG_PRESS   <= (state == ST_PRESS1) && (state_nxt == ST_LONG_HELD);
            REPEAT       <= (state == ST_LONG_HELD) && !leave && rpt_hit;
            HELD         <= is_held(state_nxt);
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with 1 tick = 4 CLK, LONG=10,
// DBL=5, REPEAT=3. Inputs change on the falling edge, outputs are sampled on
// the falling edge; pulse positions are logged as cycle indices.
module tb_key_event_decoder;

    logic CLK = 1'b0;
    logic nRST;
    logic KEY_FLAG;
    logic KEY_STATE;
    logic SHORT_PRESS;
    logic DOUBLE_CLICK;
    logic LONG_PRESS;
    logic REPEAT;
    logic HELD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_short, n_double, n_long, n_repeat;
    int at_short, at_double, at_long, at_rpt_first, at_rpt_last;
    int n_multi = 0;
    int p, r, r2;

    key_event_decoder #(
        .TICK_DIV  (4),
        .LONG_MS   (10),
        .DBL_MS    (5),
        .REPEAT_MS (3),
        .MS_W      (16)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .KEY_FLAG     (KEY_FLAG),
        .KEY_STATE    (KEY_STATE),
        .SHORT_PRESS  (SHORT_PRESS),
        .DOUBLE_CLICK (DOUBLE_CLICK),
        .LONG_PRESS   (LONG_PRESS),
        .REPEAT       (REPEAT),
        .HELD         (HELD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_double = 0; n_long = 0; n_repeat = 0;
        at_short = -1; at_double = -1; at_long = -1;
        at_rpt_first = -1; at_rpt_last = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            cyc++;
            if (SHORT_PRESS)  begin n_short++;  at_short  = cyc; end
            if (DOUBLE_CLICK) begin n_double++; at_double = cyc; end
            if (LONG_PRESS)   begin n_long++;   at_long   = cyc; end
            if (REPEAT) begin
                if (n_repeat == 0) at_rpt_first = cyc;
                n_repeat++;
                at_rpt_last = cyc;
            end
            if ((int'(SHORT_PRESS) + int'(DOUBLE_CLICK) + int'(LONG_PRESS) + int'(REPEAT)) > 1)
                n_multi++;
        end
    endtask

    // One debounced edge: flag high for exactly one rising edge.
    task automatic key(input logic s);
        KEY_FLAG  = 1'b1;
        KEY_STATE = s;
        step(1);
        KEY_FLAG  = 1'b0;
    endtask

    initial begin
        nRST      = 1'b0;
        KEY_FLAG  = 1'b0;
        KEY_STATE = 1'b1;
        clear_counts();
        step(3);
        check("reset_outputs", int'({SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT, HELD}), 0);
        nRST = 1'b1;
        step(2);

        // 1: short press
        clear_counts();
        key(1'b0);
        check("t1_held_on_press", int'(HELD), 1);
        step(12);
        key(1'b1);
        r = cyc;
        check("t1_held_off_release", int'(HELD), 0);
        step(30);
        check("t1_short_count", n_short, 1);
        check("t1_short_latency", at_short - r, 20);
        check("t1_other_pulses", n_double + n_long + n_repeat, 0);

        // 2: double click
        clear_counts();
        key(1'b0);
        check("t2_held_press1", int'(HELD), 1);
        step(8);
        key(1'b1);
        check("t2_held_release1", int'(HELD), 0);
        step(8);
        check("t2_held_wait2", int'(HELD), 0);
        key(1'b0);
        check("t2_held_press2", int'(HELD), 1);
        step(8);
        key(1'b1);
        r2 = cyc;
        check("t2_held_release2", int'(HELD), 0);
        check("t2_double_latency", at_double - r2, 0);
        step(30);
        check("t2_double_count", n_double, 1);
        check("t2_no_short", n_short, 0);

        // 3: long press with auto-repeat
        clear_counts();
        key(1'b0);
        p = cyc;
        step(76);
        key(1'b1);
        check("t3_held_after_release", int'(HELD), 0);
        step(20);
        check("t3_long_count", n_long, 1);
        check("t3_long_at", at_long - p, 40);
        check("t3_repeat_count", n_repeat, 3);
        check("t3_repeat_first", at_rpt_first - p, 52);
        check("t3_repeat_last", at_rpt_last - p, 76);
        check("t3_no_short_double", n_short + n_double, 0);

        // 4: second press coincides with the gap timeout tick
        clear_counts();
        key(1'b0);
        step(4);
        key(1'b1);
        step(19);
        key(1'b0);
        check("t4_held_press2", int'(HELD), 1);
        check("t4_no_short_at_tie", n_short, 0);
        step(4);
        key(1'b1);
        step(30);
        check("t4_double_count", n_double, 1);
        check("t4_no_short", n_short, 0);

        // 5: reset during LONG_HELD
        clear_counts();
        key(1'b0);
        step(52);
        check("t5_repeat_before_rst", int'(REPEAT), 1);
        check("t5_held_before_rst", int'(HELD), 1);
        nRST = 1'b0;
        #1;
        check("t5_outputs_in_rst", int'({SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT, HELD}), 0);
        step(3);
        nRST = 1'b1;
        clear_counts();
        step(2);
        key(1'b1);
        check("t5_held_after_rst", int'(HELD), 0);
        step(30);
        check("t5_no_pulse_after_rst", n_short + n_double + n_long + n_repeat, 0);
        clear_counts();
        key(1'b0);
        step(4);
        key(1'b1);
        r = cyc;
        step(25);
        check("t5_short_count", n_short, 1);
        check("t5_short_latency", at_short - r, 20);

        // 6: duplicate press edge in PRESS1
        clear_counts();
        key(1'b0);
        p = cyc;
        step(5);
        key(1'b0);
        check("t6_held_after_dup", int'(HELD), 1);
        step(40);
        key(1'b1);
        step(10);
        check("t6_long_count", n_long, 1);
        check("t6_long_at", at_long - p, 40);
        check("t6_no_other", n_short + n_double + n_repeat, 0);

        check("pulse_exclusive", n_multi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
